// File: rtl/regfile_scoreboard_pkg.sv
// Shared processor constants: datapath/regfile sizing, ALU operations and major opcodes.
// Register address width is derived here from the default register count.
package regfile_scoreboard_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Pending-producer bit per register, registered popcount and sticky spurious-writeback flag.
// Updates at the rising edge; issue_ready is combinational from current pending state and writeback.
// Backpressure: an issue to a still-pending destination is held off until its writeback arrives.
module scoreboard_bits
   import regfile_scoreboard_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_rd,
   output logic [NREGS-1:0] pending,
   output logic             issue_ready,
   output logic [AW:0]      pend_count,
   output logic             spurious_wb
);

   logic             wr_clr;
   logic             accept;
   logic             inc;
   logic             dec;
   logic [NREGS-1:0] pend_nxt;

   assign wr_clr      = wr_en && (wr_addr != '0);
   assign issue_ready = !pending[issue_rd] || (wr_en && (wr_addr == issue_rd));
   assign accept      = issue_en && issue_ready && (issue_rd != '0);

   // Count only real bit transitions; a clear that is immediately re-set nets to zero.
   assign inc = accept && !pending[issue_rd];
   assign dec = wr_clr && pending[wr_addr] && !(accept && (issue_rd == wr_addr));

   always_comb begin
      pend_nxt = pending;
      if (wr_clr)
         pend_nxt[wr_addr] = 1'b0;
      if (accept)
         pend_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending     <= '0;
         pend_count  <= '0;
         spurious_wb <= 1'b0;
      end else begin
         pending    <= pend_nxt;
         pend_count <= pend_count + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
         if (wr_clr && !pending[wr_addr])
            spurious_wb <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with x0 hardwired, same-cycle write bypass, and an issue scoreboard.
// Reads are combinational; writes and scoreboard state update at the rising edge.
// Backpressure: issue_ready drops while the requested destination still has a producer in flight.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   output logic [AW:0]     pend_count,
   output logic            spurious_wb
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic             wr_hit;

   assign wr_hit = wr_en && (wr_addr != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_hit) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // x0 is forced to zero on read regardless of array content.
   assign rs1_data = (rs1_addr == '0) ? '0 :
                     (wr_hit && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
   assign rs2_data = (rs2_addr == '0) ? '0 :
                     (wr_hit && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];

   assign rs1_busy = pending[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
   assign rs2_busy = pending[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));

   scoreboard_bits #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_bits (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .pending     (pending),
      .issue_ready (issue_ready),
      .pend_count  (pend_count),
      .spurious_wb (spurious_wb)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [5:0]  pend_count;
   logic        spurious_wb;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] rm [32];
   logic        pm [32];
   logic        spm;

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .pend_count  (pend_count),
      .spurious_wb (spurious_wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         rm[i] = '0;
         pm[i] = 1'b0;
      end
      spm = 1'b0;
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 32; i++)
         if (pm[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (we && wa == a) return wd;
      return rm[a];
   endfunction

   // One clock: drive at posedge+1, check at negedge, update model at the next posedge.
   task automatic cyc(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
      logic acc;
      logic rdy;
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_rd = rd; rs1_addr = a1; rs2_addr = a2;
      #4;
      rdy = !pm[rd] || (we && wa == rd);
      chk("rs1_data", rs1_data, exp_read(a1, we, wa, wd));
      chk("rs2_data", rs2_data, exp_read(a2, we, wa, wd));
      chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, pm[a1] && !(we && wa == a1)});
      chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, pm[a2] && !(we && wa == a2)});
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, rdy});
      chk("pend_count", {26'b0, pend_count}, 32'(model_count()));
      chk("spurious_wb", {31'b0, spurious_wb}, {31'b0, spm});
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         acc = ie && rdy && rd != 0;
         if (we && wa != 0) begin
            if (!pm[wa]) spm = 1'b1;
            rm[wa] = wd;
            pm[wa] = 1'b0;
         end
         if (acc) pm[rd] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      cyc(0, 0, 0, 0, 0, 0, a1, a2);
   endtask

   initial begin
      reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
      issue_en = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();

      // Post-reset state
      idle(5, 7);

      // Bypass then array read of x5
      cyc(0, 1, 5, 32'h1234, 0, 0, 5, 0);
      idle(5, 5);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // x0 writes and issues are dropped
      cyc(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
      idle(0, 0);

      // WAW hazard on x7
      cyc(0, 0, 0, 0, 1, 7, 0, 7);
      cyc(0, 0, 0, 0, 1, 7, 0, 7);
      cyc(0, 1, 7, 32'h77, 1, 7, 0, 7);
      cyc(0, 1, 7, 32'h78, 0, 0, 7, 7);
      idle(7, 7);

      // Same-cycle issue and writeback to pending x3
      cyc(0, 0, 0, 0, 1, 3, 3, 0);
      cyc(0, 1, 3, 32'd9, 1, 3, 3, 3);
      idle(3, 3);

      // Spurious writeback to x12 is sticky until reset
      cyc(0, 1, 12, 32'hABCD, 0, 0, 12, 0);
      idle(12, 0);
      idle(0, 12);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(12, 0);

      // Fill every pending bit, then reset with a write in flight
      for (int i = 1; i < 32; i++)
         cyc(0, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i - 1));
      idle(31, 1);
      for (int i = 1; i < 16; i++)
         cyc(0, 1, 5'(i), 32'(i * 3), 1, 5'(i), 5'(i), 0);
      cyc(1, 1, 5, 32'hDEAD_BEEF, 1, 9, 5, 9);
      idle(5, 9);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic rst_r;
         logic we_r;
         logic ie_r;
         rst_r = ($urandom_range(199) == 0);
         we_r  = ($urandom_range(2) != 0);
         ie_r  = ($urandom_range(1) != 0);
         cyc(rst_r, we_r, 5'($urandom_range(31)), $urandom, ie_r, 5'($urandom_range(31)),
             5'($urandom_range(31)), 5'($urandom_range(31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
